// File: rtl/cpu_pkg.sv
// Shared register-file geometry and the write-port request type used by the
// writeback arbiter and its scoreboard.
package cpu_pkg;
  localparam int REG_IDX_W = 5;
  localparam int XLEN      = 32;
  localparam int NUM_REGS  = 32;

  typedef logic [REG_IDX_W-1:0] reg_idx_t;
  typedef logic [XLEN-1:0]      xword_t;

  typedef struct packed {
    logic     we;
    reg_idx_t waddr;
    xword_t   wdata;
  } wb_req_t;

  function automatic logic [NUM_REGS-1:0] idx_onehot(input reg_idx_t idx);
    return NUM_REGS'(1) << idx;
  endfunction
endpackage

// File: rtl/wb_port_arbiter_if.sv
// Bus bundle between the writeback arbiter and its neighbours: WB stage,
// decode (LU issue and hazard lookup), LU result path and register-file port.
interface wb_port_arbiter_if;
  import cpu_pkg::*;

  logic     pipe_we;
  reg_idx_t pipe_waddr;
  xword_t   pipe_wdata;
  logic     pipe_stall;

  logic     lu_issue_valid;
  reg_idx_t lu_issue_rd;
  logic     lu_issue_ready;

  logic     lu_res_valid;
  reg_idx_t lu_res_rd;
  xword_t   lu_res_data;
  logic     lu_res_ready;

  reg_idx_t dec_rs1, dec_rs2, dec_rd;
  logic     hz_rs1, hz_rs2, hz_rd;

  logic     rf_we;
  reg_idx_t rf_waddr;
  xword_t   rf_wdata;

  // Arbiter side
  modport slave (
    input  pipe_we, pipe_waddr, pipe_wdata,
    input  lu_issue_valid, lu_issue_rd,
    input  lu_res_valid, lu_res_rd, lu_res_data,
    input  dec_rs1, dec_rs2, dec_rd,
    output pipe_stall, lu_issue_ready, lu_res_ready,
    output hz_rs1, hz_rs2, hz_rd,
    output rf_we, rf_waddr, rf_wdata
  );

  // Pipeline / environment side
  modport master (
    output pipe_we, pipe_waddr, pipe_wdata,
    output lu_issue_valid, lu_issue_rd,
    output lu_res_valid, lu_res_rd, lu_res_data,
    output dec_rs1, dec_rs2, dec_rd,
    input  pipe_stall, lu_issue_ready, lu_res_ready,
    input  hz_rs1, hz_rs2, hz_rd,
    input  rf_we, rf_waddr, rf_wdata
  );
endinterface

// File: rtl/wb_scoreboard.sv
// Pending-destination mask and outstanding-op counter for the long-latency
// unit. Issue readiness looks only at registered state, so a drain in the
// same cycle never unblocks an issue early.
module wb_scoreboard
  import cpu_pkg::*;
#(
  parameter int MAX_OUTSTANDING = 2
) (
  input  logic     clk,
  input  logic     rst_n,
  input  logic     issue_valid,
  input  reg_idx_t issue_rd,
  output logic     issue_ready,
  input  logic     drain,
  input  reg_idx_t drain_rd,
  input  logic     discard,
  input  reg_idx_t dec_rs1,
  input  reg_idx_t dec_rs2,
  input  reg_idx_t dec_rd,
  output logic     hz_rs1,
  output logic     hz_rs2,
  output logic     hz_rd
);
  localparam int CNT_W = $clog2(MAX_OUTSTANDING + 1);

  logic [NUM_REGS-1:0] pending, set_mask, clr_mask;
  logic [CNT_W-1:0]    outstanding;
  logic                issue_fire, retire;

  assign issue_ready = !pending[issue_rd] && (outstanding < CNT_W'(MAX_OUTSTANDING));
  assign issue_fire  = issue_valid && issue_ready;
  assign retire      = drain || discard;

  assign hz_rs1 = (dec_rs1 != '0) && pending[dec_rs1];
  assign hz_rs2 = (dec_rs2 != '0) && pending[dec_rs2];
  assign hz_rd  = (dec_rd  != '0) && pending[dec_rd];

  // Build set/clear masks; a same-edge set of the drained index wins.
  always_comb begin
    set_mask = '0;
    clr_mask = '0;
    if (issue_fire && issue_rd != '0) set_mask = idx_onehot(issue_rd);
    if (drain) clr_mask = idx_onehot(drain_rd);
  end

  // Pending mask and outstanding count; issue plus retire leaves the count alone.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      pending     <= '0;
      outstanding <= '0;
    end else begin
      pending <= (pending & ~clr_mask) | set_mask;
      case ({issue_fire, retire})
        2'b10:   outstanding <= outstanding + CNT_W'(1);
        2'b01:   if (outstanding != '0) outstanding <= outstanding - CNT_W'(1);
        default: outstanding <= outstanding;
      endcase
    end
  end
endmodule

// File: rtl/wb_port_arbiter.sv
// Owns the register file write port. The WB stage always wins; a one-entry
// holding buffer parks LU results until the port is idle, and a wait counter
// forces a one-cycle WB bubble when a result has waited too long.
module wb_port_arbiter
  import cpu_pkg::*;
#(
  parameter int STARVE_LIMIT    = 4,
  parameter int MAX_OUTSTANDING = 2
) (
  input logic               clk,
  input logic               rst_n,
  wb_port_arbiter_if.slave  bus
);
  localparam int WAIT_W = (STARVE_LIMIT > 1) ? $clog2(STARVE_LIMIT) : 1;
  localparam logic [WAIT_W-1:0] WAIT_LAST = WAIT_W'(STARVE_LIMIT - 1);

  logic              pipe_act, drain, res_fire, res_load, res_discard;
  logic              buf_valid, stall;
  reg_idx_t          buf_rd;
  xword_t            buf_data;
  logic [WAIT_W-1:0] wait_cnt;
  wb_req_t           port;

  assign pipe_act    = bus.pipe_we && (bus.pipe_waddr != '0);
  assign drain       = buf_valid && !pipe_act;
  assign res_fire    = bus.lu_res_valid && !buf_valid;
  assign res_load    = res_fire && (bus.lu_res_rd != '0);
  assign res_discard = res_fire && (bus.lu_res_rd == '0);

  assign bus.lu_res_ready = !buf_valid;
  assign bus.pipe_stall   = stall;

  // Write-port mux: pipeline first, then the held LU result, else idle.
  always_comb begin
    port = '0;
    if (pipe_act) begin
      port = '{we: 1'b1, waddr: bus.pipe_waddr, wdata: bus.pipe_wdata};
    end else if (buf_valid) begin
      port = '{we: 1'b1, waddr: buf_rd, wdata: buf_data};
    end
  end

  assign bus.rf_we    = port.we;
  assign bus.rf_waddr = port.waddr;
  assign bus.rf_wdata = port.wdata;

  // Holding buffer: load only when empty, so drain and refill never share a cycle.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      buf_valid <= 1'b0;
      buf_rd    <= '0;
      buf_data  <= '0;
    end else if (drain) begin
      buf_valid <= 1'b0;
    end else if (res_load) begin
      buf_valid <= 1'b1;
      buf_rd    <= bus.lu_res_rd;
      buf_data  <= bus.lu_res_data;
    end
  end

  // Starvation timer: count waiting cycles, raise the stall after the last one.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      wait_cnt <= '0;
      stall    <= 1'b0;
    end else if (drain) begin
      wait_cnt <= '0;
      stall    <= 1'b0;
    end else if (buf_valid) begin
      if (wait_cnt == WAIT_LAST) stall <= 1'b1;
      else wait_cnt <= wait_cnt + WAIT_W'(1);
    end
  end

  wb_scoreboard #(.MAX_OUTSTANDING(MAX_OUTSTANDING)) u_sb (
    .clk         (clk),
    .rst_n       (rst_n),
    .issue_valid (bus.lu_issue_valid),
    .issue_rd    (bus.lu_issue_rd),
    .issue_ready (bus.lu_issue_ready),
    .drain       (drain),
    .drain_rd    (buf_rd),
    .discard     (res_discard),
    .dec_rs1     (bus.dec_rs1),
    .dec_rs2     (bus.dec_rs2),
    .dec_rd      (bus.dec_rd),
    .hz_rs1      (bus.hz_rs1),
    .hz_rs2      (bus.hz_rs2),
    .hz_rd       (bus.hz_rd)
  );

  // A WB write while stalled still wins the port, but it breaks the handshake.
  stall_protocol: assert property (@(posedge clk) disable iff (!rst_n) !(stall && pipe_act));
endmodule

// File: tb/tb_wb_port_arbiter.sv
// Directed bench for wb_port_arbiter: expected register-file writes are queued
// as stimulus is driven and checked by a write-port monitor; flag and
// handshake outputs are checked inline.
module tb_wb_port_arbiter;
  import cpu_pkg::*;

  logic clk;
  logic rst_n;
  int   n_assert = 0;
  int   n_fail   = 0;

  wb_req_t exp_q[$];
  wb_req_t exp_item;

  wb_port_arbiter_if bus ();

  wb_port_arbiter #(.STARVE_LIMIT(4), .MAX_OUTSTANDING(2)) dut (
    .clk   (clk),
    .rst_n (rst_n),
    .bus   (bus)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  function automatic wb_req_t mk(input reg_idx_t a, input xword_t d);
    return '{we: 1'b1, waddr: a, wdata: d};
  endfunction

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    n_assert++;
    assert (obs === exp) else begin
      n_fail++;
      $error("FAIL %s observed=0x%0h expected=0x%0h", tag, obs, exp);
    end
  endtask

  task automatic cyc();
    @(posedge clk);
    #1;
  endtask

  // Every register-file write must match the next queued expectation.
  always @(negedge clk) begin
    if (rst_n && bus.rf_we) begin
      n_assert++;
      assert (exp_q.size() != 0) else begin
        n_fail++;
        $error("FAIL rf_write_unexpected observed=%0d:0x%0h expected=none", bus.rf_waddr, bus.rf_wdata);
      end
      if (exp_q.size() != 0) begin
        exp_item = exp_q.pop_front();
        n_assert++;
        assert ({bus.rf_waddr, bus.rf_wdata} === {exp_item.waddr, exp_item.wdata}) else begin
          n_fail++;
          $error("FAIL rf_write observed=%0d:0x%0h expected=%0d:0x%0h",
                 bus.rf_waddr, bus.rf_wdata, exp_item.waddr, exp_item.wdata);
        end
      end
    end
  end

  initial begin
    #200000;
    $display("FAIL watchdog observed=timeout expected=finish");
    $fatal(1, "watchdog expired");
  end

  initial begin
    rst_n = 1'b1;
    bus.pipe_we = 1'b0; bus.pipe_waddr = '0; bus.pipe_wdata = '0;
    bus.lu_issue_valid = 1'b0; bus.lu_issue_rd = '0;
    bus.lu_res_valid = 1'b0; bus.lu_res_rd = '0; bus.lu_res_data = '0;
    bus.dec_rs1 = 5'd7; bus.dec_rs2 = 5'd7; bus.dec_rd = 5'd7;
    #1 rst_n = 1'b0;
    #2;
    chk("rst_rf_we", bus.rf_we, 0);
    chk("rst_res_ready", bus.lu_res_ready, 1);
    chk("rst_issue_ready", bus.lu_issue_ready, 1);
    chk("rst_stall", bus.pipe_stall, 0);
    chk("rst_hz_rs1", bus.hz_rs1, 0);
    chk("rst_hz_rs2", bus.hz_rs2, 0);
    chk("rst_hz_rd", bus.hz_rd, 0);
    cyc(); cyc();
    rst_n = 1'b1;
    bus.dec_rs1 = '0; bus.dec_rs2 = '0;

    // Plain WB write goes straight through
    cyc();
    bus.pipe_we = 1'b1; bus.pipe_waddr = 5'd5; bus.pipe_wdata = 32'h11; bus.dec_rd = 5'd5;
    exp_q.push_back(mk(5'd5, 32'h11));
    #2;
    chk("wb_we", bus.rf_we, 1);
    chk("wb_waddr", bus.rf_waddr, 5);
    chk("wb_wdata", bus.rf_wdata, 32'h11);
    chk("wb_hz_rd", bus.hz_rd, 0);
    chk("wb_res_ready", bus.lu_res_ready, 1);
    cyc();
    bus.pipe_waddr = 5'd0; bus.pipe_wdata = 32'h22;
    #2;
    chk("wb_x0_no_write", bus.rf_we, 0);

    // Issue rd=7, duplicate blocked, result drained while WB idle
    cyc();
    bus.pipe_we = 1'b0; bus.lu_issue_valid = 1'b1; bus.lu_issue_rd = 5'd7;
    #2;
    chk("issue7_ready", bus.lu_issue_ready, 1);
    cyc();
    bus.dec_rd = 5'd7; bus.dec_rs1 = 5'd7; bus.dec_rs2 = 5'd0;
    #2;
    chk("hz_rd7", bus.hz_rd, 1);
    chk("hz_rs1_7", bus.hz_rs1, 1);
    chk("hz_rs2_x0", bus.hz_rs2, 0);
    chk("issue7_dup_ready", bus.lu_issue_ready, 0);
    bus.lu_issue_valid = 1'b0;
    cyc();
    bus.lu_res_valid = 1'b1; bus.lu_res_rd = 5'd7; bus.lu_res_data = 32'hABCD;
    #2;
    chk("res7_ready", bus.lu_res_ready, 1);
    chk("res7_no_write_yet", bus.rf_we, 0);
    cyc();
    bus.lu_res_valid = 1'b0;
    exp_q.push_back(mk(5'd7, 32'hABCD));
    #2;
    chk("res7_drain_we", bus.rf_we, 1);
    chk("res7_buf_full", bus.lu_res_ready, 0);
    chk("res7_hz_still", bus.hz_rd, 1);
    cyc();
    #2;
    chk("res7_hz_clear", bus.hz_rd, 0);
    chk("res7_buf_empty", bus.lu_res_ready, 1);
    chk("res7_idle", bus.rf_we, 0);

    // Outstanding limit
    bus.dec_rs1 = '0;
    cyc();
    bus.lu_issue_valid = 1'b1; bus.lu_issue_rd = 5'd3;
    #2; chk("issue3_ready", bus.lu_issue_ready, 1);
    cyc();
    bus.lu_issue_rd = 5'd4;
    #2; chk("issue4_ready", bus.lu_issue_ready, 1);
    cyc();
    bus.lu_issue_rd = 5'd5; bus.dec_rd = 5'd4;
    #2;
    chk("issue5_full", bus.lu_issue_ready, 0);
    chk("hz_rd4", bus.hz_rd, 1);
    bus.lu_issue_valid = 1'b0;
    cyc();
    bus.lu_res_valid = 1'b1; bus.lu_res_rd = 5'd3; bus.lu_res_data = 32'h33;
    cyc();
    bus.lu_res_valid = 1'b0;
    exp_q.push_back(mk(5'd3, 32'h33));
    #2; chk("issue5_during_drain", bus.lu_issue_ready, 0);
    cyc();
    #2; chk("issue5_after_drain", bus.lu_issue_ready, 1);
    bus.lu_res_valid = 1'b1; bus.lu_res_rd = 5'd4; bus.lu_res_data = 32'h44;
    cyc();
    bus.lu_res_valid = 1'b0;
    exp_q.push_back(mk(5'd4, 32'h44));
    cyc();
    #2; chk("hz_rd4_clear", bus.hz_rd, 0);

    // Starvation: rd=9 held behind continuous WB writes
    cyc();
    bus.lu_issue_valid = 1'b1; bus.lu_issue_rd = 5'd9;
    #2; chk("issue9_ready", bus.lu_issue_ready, 1);
    for (int i = 0; i < 5; i++) begin
      cyc();
      bus.lu_issue_valid = 1'b0;
      bus.pipe_we = 1'b1; bus.pipe_waddr = 5'(i + 1); bus.pipe_wdata = 32'h1000 + 32'(i);
      exp_q.push_back(mk(5'(i + 1), 32'h1000 + 32'(i)));
      bus.lu_res_valid = (i == 0);
      bus.lu_res_rd = 5'd9; bus.lu_res_data = 32'h99;
      #2;
      chk("starve_no_stall", bus.pipe_stall, 0);
      chk("starve_res_ready", bus.lu_res_ready, (i == 0) ? 1 : 0);
    end
    cyc();
    bus.pipe_we = 1'b0; bus.dec_rd = 5'd9;
    exp_q.push_back(mk(5'd9, 32'h99));
    #2;
    chk("starve_stall", bus.pipe_stall, 1);
    chk("starve_drain_we", bus.rf_we, 1);
    chk("starve_drain_addr", bus.rf_waddr, 9);
    chk("starve_hz9", bus.hz_rd, 1);
    cyc();
    #2;
    chk("starve_stall_clear", bus.pipe_stall, 0);
    chk("starve_res_ready", bus.lu_res_ready, 1);
    chk("starve_hz9_clear", bus.hz_rd, 0);

    // Same-edge drain of rd=3 and issue of rd=3 (rd=3 not pending)
    cyc();
    bus.lu_issue_valid = 1'b1; bus.lu_issue_rd = 5'd10;
    cyc();
    bus.lu_issue_valid = 1'b0;
    bus.pipe_we = 1'b1; bus.pipe_waddr = 5'd2; bus.pipe_wdata = 32'h222;
    exp_q.push_back(mk(5'd2, 32'h222));
    bus.lu_res_valid = 1'b1; bus.lu_res_rd = 5'd3; bus.lu_res_data = 32'h333;
    cyc();
    bus.lu_res_valid = 1'b0; bus.pipe_we = 1'b0;
    bus.lu_issue_valid = 1'b1; bus.lu_issue_rd = 5'd3; bus.dec_rd = 5'd3;
    exp_q.push_back(mk(5'd3, 32'h333));
    #2;
    chk("same3_hz_before", bus.hz_rd, 0);
    chk("same3_issue_ready", bus.lu_issue_ready, 1);
    chk("same3_drain_addr", bus.rf_waddr, 3);
    cyc();
    bus.lu_issue_valid = 1'b0;
    #2;
    chk("same3_pending_after", bus.hz_rd, 1);

    // Same-edge drain of rd=3 and issue of rd=6: outstanding stays at 1
    cyc();
    bus.pipe_we = 1'b1; bus.pipe_waddr = 5'd2; bus.pipe_wdata = 32'h2B;
    exp_q.push_back(mk(5'd2, 32'h2B));
    bus.lu_res_valid = 1'b1; bus.lu_res_rd = 5'd3; bus.lu_res_data = 32'h3B;
    cyc();
    bus.lu_res_valid = 1'b0; bus.pipe_we = 1'b0;
    bus.lu_issue_valid = 1'b1; bus.lu_issue_rd = 5'd6;
    exp_q.push_back(mk(5'd3, 32'h3B));
    #2;
    chk("drain3_issue6_ready", bus.lu_issue_ready, 1);
    cyc();
    bus.lu_issue_rd = 5'd11; bus.dec_rs1 = 5'd6;
    #2;
    chk("drain3_hz3_clear", bus.hz_rd, 0);
    chk("issue6_pending", bus.hz_rs1, 1);
    chk("out_unchanged_one_slot", bus.lu_issue_ready, 1);
    cyc();
    bus.lu_issue_valid = 1'b0; bus.lu_issue_rd = 5'd13;
    #2;
    chk("out_unchanged_now_full", bus.lu_issue_ready, 0);

    // Retire 10 and 6, issue 12, hold result 11, then reset mid-operation
    cyc();
    bus.lu_res_valid = 1'b1; bus.lu_res_rd = 5'd10; bus.lu_res_data = 32'hA0;
    cyc();
    bus.lu_res_valid = 1'b0;
    exp_q.push_back(mk(5'd10, 32'hA0));
    cyc();
    bus.lu_res_valid = 1'b1; bus.lu_res_rd = 5'd6; bus.lu_res_data = 32'h60;
    cyc();
    bus.lu_res_valid = 1'b0;
    exp_q.push_back(mk(5'd6, 32'h60));
    cyc();
    bus.lu_issue_valid = 1'b1; bus.lu_issue_rd = 5'd12;
    #2; chk("issue12_ready", bus.lu_issue_ready, 1);
    cyc();
    bus.lu_issue_valid = 1'b0;
    bus.pipe_we = 1'b1; bus.pipe_waddr = 5'd8; bus.pipe_wdata = 32'h800;
    exp_q.push_back(mk(5'd8, 32'h800));
    bus.lu_res_valid = 1'b1; bus.lu_res_rd = 5'd11; bus.lu_res_data = 32'hB1;
    cyc();
    bus.lu_res_valid = 1'b0; bus.pipe_wdata = 32'h801;
    bus.dec_rd = 5'd12; bus.lu_issue_rd = 5'd12;
    #2;
    chk("pre_rst_hz12", bus.hz_rd, 1);
    chk("pre_rst_buf_full", bus.lu_res_ready, 0);
    chk("pre_rst_issue12_blocked", bus.lu_issue_ready, 0);
    bus.pipe_we = 1'b0;
    rst_n = 1'b0;
    #1;
    chk("async_rst_rf_we", bus.rf_we, 0);
    chk("async_rst_res_ready", bus.lu_res_ready, 1);
    chk("async_rst_hz12", bus.hz_rd, 0);
    chk("async_rst_issue_ready", bus.lu_issue_ready, 1);
    chk("async_rst_stall", bus.pipe_stall, 0);
    cyc(); cyc();
    rst_n = 1'b1;
    cyc();
    #2;
    chk("post_rst_idle", bus.rf_we, 0);
    chk("post_rst_hz12", bus.hz_rd, 0);
    cyc();
    bus.pipe_we = 1'b1; bus.pipe_waddr = 5'd31; bus.pipe_wdata = 32'hFFFF;
    exp_q.push_back(mk(5'd31, 32'hFFFF));
    #2;
    chk("post_rst_wb_addr", bus.rf_waddr, 31);
    cyc();
    bus.pipe_we = 1'b0;
    #6;

    n_assert++;
    assert (exp_q.size() == 0) else begin
      n_fail++;
      $error("FAIL writes_outstanding observed=%0d expected=0", exp_q.size());
    end

    $display("End of test - %0d assertions evaluated, %0d failures", n_assert, n_fail);
    $finish;
  end
endmodule

// File: doc/wb_port_arbiter.md
Name: wb_port_arbiter

Overview:
- Owns the register file's single write port.
- Shares that port between the in-order pipeline writeback (WB) stage and one long-latency unit (LU: mul/div) result.
- Keeps a 32-entry pending scoreboard for LU destinations, used by the decode hazard logic.
- Drives rf_we/rf_waddr/rf_wdata straight into the register file write port, so the file's same-cycle write bypass stays valid.

Parameters:
- STARVE_LIMIT, 4, cycles a held LU result may wait before the arbiter forces a WB bubble (≥1).
- MAX_OUTSTANDING, 2, maximum LU ops issued and not yet written back (≥1).

Ports:
- clk  in  1  system clock
- rst_n  in  1  asynchronous active-low reset
- pipe_we  in  1  WB stage write request (no backpressure)
- pipe_waddr  in  5  WB destination
- pipe_wdata  in  32  WB data
- pipe_stall  out  1  registered; WB must present pipe_we=0 while high
- lu_issue_valid  in  1  decode issues an LU op
- lu_issue_rd  in  5  LU destination
- lu_issue_ready  out  1  issue accepted when valid&ready
- lu_res_valid  in  1  LU result valid
- lu_res_rd  in  5  result destination
- lu_res_data  in  32  result data
- lu_res_ready  out  1  holding buffer empty
- dec_rs1, dec_rs2, dec_rd  in  5 each  decode operand/destination indices
- hz_rs1, hz_rs2, hz_rd  out  1 each  combinational: index nonzero and pending
- rf_we  out  1  write enable to register file
- rf_waddr  out  5  write address
- rf_wdata  out  32  write data

Behaviour:
- Reset (async, rst_n=0):
  - pending=0, outstanding=0, buffer empty, wait_cnt=0, pipe_stall=0.
  - Outputs during reset: rf_we=0, lu_res_ready=1, lu_issue_ready=1, hz_*=0.
- pipe_act = pipe_we && pipe_waddr!=0.
- Write port (combinational):
  - If pipe_act: port driven from pipe_* (0 latency).
  - Else if buf_valid: port driven from buffer; this is a "drain".
  - Else: rf_we=0, rf_waddr=0, rf_wdata=0.
- Holding buffer (1 entry):
  - lu_res_ready = !buf_valid. There is no drain-and-refill in the same cycle.
  - lu_res_valid && lu_res_ready at edge t loads rd/data; buf_valid=1 from t+1.
  - A result with rd=0 is accepted and discarded (no buffer load) and decrements outstanding.
  - Drain at edge t clears buf_valid, clears pending[rd] and decrements outstanding, all at edge t.
- Scoreboard:
  - lu_issue_ready = !pending[lu_issue_rd] && outstanding<MAX_OUTSTANDING, evaluated on registered state only (no same-cycle clear bypass).
  - Issue with rd!=0 sets pending[rd] and increments outstanding at the edge.
  - Issue with rd=0 increments outstanding only.
  - Simultaneous issue and drain: both take effect; outstanding unchanged.
- Starvation:
  - wait_cnt increments each cycle buf_valid && !drain.
  - When wait_cnt reaches STARVE_LIMIT-1 at an edge, pipe_stall=1 from the next cycle.
  - The first cycle with pipe_stall=1 and pipe_we=0 drains. At that edge pipe_stall←0 and wait_cnt←0.
  - wait_cnt also clears on any drain.
  - pipe_act while pipe_stall=1 is a protocol violation: the pipeline still wins and an assertion fires.
- Reset mid-operation discards the buffered result and all pending state. The LU is reset by the same rst_n.

Decomposition:
- Shared package cpu_pkg: REG_IDX_W=5, XLEN=32, NUM_REGS=32, typedef wb_req_t {we, waddr, wdata}.
- Natural sub-module: wb_scoreboard, holding the pending mask, outstanding counter, issue_ready and hz_* lookup.
- Buffer, starvation counter and port mux stay in the top module.

Test Plan:
- Reset, then WB we=1 waddr=5 wdata=0x11 with no LU → rf_we=1, waddr=5, wdata=0x11 in the same cycle; hz_*=0; lu_res_ready=1.
- Issue rd=7 → hz_rd=1 for dec_rd=7 next cycle. A second issue to rd=7 gets lu_issue_ready=0. Result rd=7 data=0xABCD arrives with WB idle → buffered t+1, rf write at t+1, pending[7] clear at t+2.
- Issue rd=3 and rd=4, then a third issue → lu_issue_ready=0 (outstanding=2). It goes high the cycle after the first drain.
- LU result rd=9 held while pipe_act every cycle, STARVE_LIMIT=4 → pipe_stall=1 four cycles after the buffer loads; the WB drops we, rd=9 is written, and pipe_stall=0 the next cycle.
- Drain of rd=3 and issue of rd=3 on the same edge → pending[3]=1 afterwards (issue was allowed only because pending was already clear, i.e. rd=3 had not been pending). Separately, a same-edge drain of rd=3 plus issue of rd=6 → outstanding unchanged.
- rst_n low with buffer full and pending[12]=1 → rf_we=0, lu_res_ready=1 and hz_rd(12)=0 immediately, without waiting for a clk edge.
